post_norm_fmul_seq: RTL

- Multi-cycle post-normalization and rounding unit for the FMUL path.
- Consumes the 48-bit raw mantissa product together with the biased exponent, sign and exponent-overflow flags from the multiply pre-normalization stage.
- Normalizes iteratively (one bit per cycle), rounds per IEEE-754 single precision, and emits the packed 32-bit result plus exception flags.
- Valid/ready handshake on both sides.

---
 rtl/post_norm_fmul_seq.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/post_norm_fmul_seq.sv
// Multi-cycle post-normalization and rounding stage for the single-precision multiplier.
// Normalizes one bit per cycle, rounds once, and holds the packed result until it is taken.
module post_norm_fmul_seq #(
    parameter int MAX_DN_SHIFT = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] fract_in,
    input  logic [7:0]  exp_in,
    input  logic [1:0]  exp_ovf,
    input  logic        sign_in,
    input  logic        inf_in,
    input  logic        op_inf,
    input  logic        op_nan,
    input  logic [1:0]  rmode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RZ  = 2'b01;
    localparam logic [1:0] RM_UP  = 2'b10;

    localparam logic signed [9:0] DN_LIMIT = 10'(1 - MAX_DN_SHIFT);
    localparam logic signed [9:0] E_ONE    = 10'sd1;
    localparam logic signed [9:0] E_MAX    = 10'sd255;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_DENORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [47:0]       m_q, m_d;
    logic              sticky_q, sticky_d;
    logic signed [9:0] e_q, e_d;
    logic              sign_q, sign_d;
    logic [1:0]        rmode_q, rmode_d;
    logic              tiny_q, tiny_d;
    logic [31:0]       result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              inx_q, inx_d;

    // Overflow saturates to infinity only when rounding points away from zero.
    function automatic logic [31:0] ovf_result(input logic s, input logic [1:0] rm);
        logic to_inf;
        case (rm)
            RM_RNE:  to_inf = 1'b1;
            RM_RZ:   to_inf = 1'b0;
            RM_UP:   to_inf = ~s;
            default: to_inf = s;
        endcase
        return to_inf ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7FFFFF};
    endfunction

    logic [23:0]       kept;
    logic              guard;
    logic              st;
    logic              rnd_inc;
    logic [24:0]       kept_sum;
    logic [23:0]       kept_rnd;
    logic signed [9:0] e_rnd;

    always_comb begin
        kept  = m_q[46:23];
        guard = m_q[22];
        st    = (|m_q[21:0]) | sticky_q;
        case (rmode_q)
            RM_RNE:  rnd_inc = guard & (st | kept[0]);
            RM_RZ:   rnd_inc = 1'b0;
            RM_UP:   rnd_inc = (guard | st) & ~sign_q;
            default: rnd_inc = (guard | st) & sign_q;
        endcase
        kept_sum = {1'b0, kept} + {24'd0, rnd_inc};
        // A carry out of the 24-bit significand renormalizes to 1.0 with a bumped exponent.
        kept_rnd = kept_sum[24] ? 24'h800000 : kept_sum[23:0];
        e_rnd    = kept_sum[24] ? e_q + E_ONE : e_q;
    end

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        sticky_d = sticky_q;
        e_d      = e_q;
        sign_d   = sign_q;
        rmode_d  = rmode_q;
        tiny_d   = tiny_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    m_d      = fract_in;
                    sticky_d = 1'b0;
                    sign_d   = sign_in;
                    rmode_d  = rmode;
                    tiny_d   = 1'b0;
                    e_d      = exp_ovf[1] ? (10'sd0 - $signed({2'b00, exp_in}))
                                          : $signed({2'b00, exp_in});
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    inx_d    = 1'b0;
                    state_d  = S_NORM;
                    if (op_nan) begin
                        result_d = 32'h7FC00000;
                        state_d  = S_DONE;
                    end else if (op_inf) begin
                        result_d = {sign_in, 8'hFF, 23'd0};
                        state_d  = S_DONE;
                    end else if (exp_ovf == 2'b11 || inf_in) begin
                        result_d = ovf_result(sign_in, rmode);
                        ovf_d    = 1'b1;
                        inx_d    = 1'b1;
                        state_d  = S_DONE;
                    end else if (fract_in == '0) begin
                        result_d = {sign_in, 31'd0};
                        state_d  = S_DONE;
                    end
                end
            end

            S_NORM: begin
                if (m_q[47]) begin
                    m_d      = m_q >> 1;
                    sticky_d = sticky_q | m_q[0];
                    e_d      = e_q + E_ONE;
                end else if (!m_q[46] && e_q > E_ONE) begin
                    m_d = m_q << 1;
                    e_d = e_q - E_ONE;
                end else if (e_q < E_ONE) begin
                    tiny_d  = 1'b1;
                    state_d = S_DENORM;
                end else begin
                    // Leaving with a hidden bit of zero at the minimum exponent is a denormal.
                    if (!m_q[46] && e_q == E_ONE) begin
                        tiny_d = 1'b1;
                    end
                    state_d = S_ROUND;
                end
            end

            S_DENORM: begin
                if (e_q < DN_LIMIT) begin
                    sticky_d = sticky_q | (|m_q);
                    m_d      = '0;
                    e_d      = E_ONE;
                    state_d  = S_ROUND;
                end else begin
                    m_d      = m_q >> 1;
                    sticky_d = sticky_q | m_q[0];
                    e_d      = e_q + E_ONE;
                    if (e_q == 10'sd0) begin
                        state_d = S_ROUND;
                    end
                end
            end

            S_ROUND: begin
                if (e_rnd >= E_MAX) begin
                    result_d = ovf_result(sign_q, rmode_q);
                    ovf_d    = 1'b1;
                    unf_d    = 1'b0;
                    inx_d    = 1'b1;
                end else begin
                    result_d = {sign_q, (kept_rnd[23] ? e_rnd[7:0] : 8'd0), kept_rnd[22:0]};
                    ovf_d    = 1'b0;
                    unf_d    = tiny_q & (guard | st);
                    inx_d    = guard | st;
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            sticky_q <= 1'b0;
            e_q      <= '0;
            sign_q   <= 1'b0;
            rmode_q  <= 2'b00;
            tiny_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            sticky_q <= sticky_d;
            e_q      <= e_d;
            sign_q   <= sign_d;
            rmode_q  <= rmode_d;
            tiny_q   <= tiny_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign inexact   = inx_q;

endmodule
